// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative RV32M multiply/divide unit that borrows the ALU adder.
// Shift-add multiply and restoring divide, one bit per cycle for 32 cycles,
// then an optional sign-fixup cycle (FIXUP_CYCLE) before the DONE pulse.
// Optional macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and divides with
// |dividend| < |divisor| complete on the special single-cycle path.
module multdiv_seq #(
  parameter int XLEN        = 32,
  parameter int FIXUP_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            alu_req_o,
  output logic            alu_sub_o,
  output logic [XLEN-1:0] multdiv_operand_a_o,
  output logic [XLEN-1:0] multdiv_operand_b_o,
  input  logic [XLEN+1:0] adder_result_ext_i
);
  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
  logic            valid_q, neg_prod_q, neg_quo_q, neg_rem_q;

  // Bit 0 of the extended adder result is the carry-in helper only.
  logic unused_ext0;
  assign unused_ext0 = adder_result_ext_i[0];

  // ---- start-time decode -------------------------------------------------
  logic            is_div, a_sgn, b_sgn, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  // Operand signedness, magnitudes and single-cycle special results.
  always_comb begin
    is_div = op_i[2];
    a_sgn  = rs1_i[XLEN-1] & (is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10));
    b_sgn  = rs2_i[XLEN-1] & (is_div ? ~op_i[0] : (op_i[1:0] == 2'b01));
    a_mag  = a_sgn ? ('0 - rs1_i) : rs1_i;
    b_mag  = b_sgn ? ('0 - rs2_i) : rs2_i;
    div0   = is_div && (rs2_i == '0);
    ovf    = is_div && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special  = div0 | ovf;
    spec_res = op_i[1] ? (div0 ? rs1_i : '0) : (div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`ifdef MULDIV_EARLY_OUT_EN
    if (!special && !is_div && (rs1_i == '0 || rs2_i == '0)) begin
      special  = 1'b1;
      spec_res = '0;
    end else if (!special && is_div && (a_mag < b_mag)) begin
      special  = 1'b1;
      spec_res = op_i[1] ? rs1_i : '0;
    end
`endif
  end

  // ---- per-iteration datapath ------------------------------------------
  logic [XLEN:0]   sum, sh;
  logic            qbit;
  logic [XLEN-1:0] hi_nx, lo_nx, fhi, flo, quo_f, rem_f, fix_res;
  logic [2*XLEN-1:0] prod_f;

  // Next accumulator values from the ALU sum, then the sign-fixed result.
  always_comb begin
    sum  = lo_q[0] ? {adder_result_ext_i[XLEN+1], adder_result_ext_i[XLEN:1]} : {1'b0, hi_q};
    sh   = {hi_q, lo_q[XLEN-1]};
    qbit = sh[XLEN] | adder_result_ext_i[XLEN+1];
    if (op_q[2]) begin
      hi_nx = qbit ? adder_result_ext_i[XLEN:1] : sh[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], qbit};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo_q[XLEN-1:1]};
    end
    // Without a fixup cycle the negate works straight off the last update.
    fhi    = (state_q == ITER) ? hi_nx : hi_q;
    flo    = (state_q == ITER) ? lo_nx : lo_q;
    prod_f = neg_prod_q ? ('0 - {fhi, flo}) : {fhi, flo};
    quo_f  = neg_quo_q ? ('0 - flo) : flo;
    rem_f  = neg_rem_q ? ('0 - fhi) : fhi;
    case (op_q)
      3'b000:          fix_res = prod_f[XLEN-1:0];
      3'b100, 3'b101:  fix_res = quo_f;
      3'b110, 3'b111:  fix_res = rem_f;
      default:         fix_res = prod_f[2*XLEN-1:XLEN];
    endcase
  end

  // ALU operand drive: only while iterating, zero otherwise.
  always_comb begin
    alu_req_o           = (state_q == ITER);
    alu_sub_o           = alu_req_o & op_q[2];
    multdiv_operand_a_o = '0;
    multdiv_operand_b_o = '0;
    if (alu_req_o) begin
      multdiv_operand_a_o = op_q[2] ? sh[XLEN-1:0] : hi_q;
      multdiv_operand_b_o = opnd_q;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Control FSM plus accumulator/result registers; flush beats start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; op_q <= '0; cnt_q <= '0;
      hi_q <= '0; lo_q <= '0; opnd_q <= '0; result_q <= '0;
      valid_q <= 1'b0; neg_prod_q <= 1'b0; neg_quo_q <= 1'b0; neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            op_q       <= op_i;
            cnt_q      <= '0;
            neg_prod_q <= !is_div & (a_sgn ^ b_sgn);
            neg_quo_q  <= is_div & (a_sgn ^ b_sgn) & !div0;
            neg_rem_q  <= is_div & a_sgn;
            hi_q       <= '0;
            lo_q       <= is_div ? a_mag : b_mag;
            opnd_q     <= is_div ? b_mag : a_mag;
            if (special) begin
              result_q <= spec_res;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= ITER;
            end
          end
        end
        ITER: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (FIXUP_CYCLE != 0) begin
              state_q <= FIXUP;
            end else begin
              result_q <= fix_res;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        FIXUP: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural ALU adder beside it.
module tb_multdiv_seq;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic        busy_o, valid_o, alu_req_o, alu_sub_o;
  logic [31:0] result_o, opa, opb;
  logic [33:0] ext;

  int total = 0, passed = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif

  always #5 clk = ~clk;

  // ALU extended adder: {a,1} + ({b,0} ^ neg), carry-out in bit 33.
  assign ext = {1'b0, opa, 1'b1} + {1'b0, ({opb, 1'b0} ^ {33{alu_sub_o}})};

  multdiv_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .flush_i(flush_i), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o),
    .alu_req_o(alu_req_o), .alu_sub_o(alu_sub_o), .multdiv_operand_a_o(opa),
    .multdiv_operand_b_o(opb), .adder_result_ext_i(ext)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Launch at cycle 0, wait (bounded) for valid_o; optional stray start at cycle intr.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int intr = -1);
    int lat = 0;
    bit alu_seen = 0, busy_ok = 1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      start_i = (c == intr);
      if (c == intr) begin op_i = 3'b000; rs1_i = 32'd1; rs2_i = 32'd1; end
      if (alu_req_o) alu_seen = 1;
      if (!busy_o) busy_ok = 0;
      if (valid_o) lat = c;
    end
    start_i = 1'b0;
    chk({tag, " result"}, result_o, exp);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy"}, busy_ok, 1);
    if (exp_lat == 1) chk({tag, " alu_req"}, alu_seen, 0);
    @(negedge clk);
    chk({tag, " post valid/busy"}, {valid_o, busy_o}, 0);
    chk({tag, " held"}, result_o, exp);
  endtask

  initial begin
    bit vseen;
    repeat (2) @(negedge clk);
    chk("reset ctl", {busy_o, valid_o, alu_req_o, alu_sub_o}, 0);
    chk("reset result", result_o, 0);
    chk("reset opa", opa, 0);
    chk("reset opb", opb, 0);
    rst = 1'b0;

    run_op("MUL", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("MULH", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_op("DIV", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("REM", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);

    // Flush a DIVU at cycle 10; previous result must survive.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
    vseen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (valid_o) vseen = 1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    if (valid_o) vseen = 1;
    chk("flush busy", busy_o, 0);
    chk("flush valid", vseen, 0);
    chk("flush result", result_o, 32'hFFFFFFFF);
    run_op("DIVU after flush", 3'b101, 32'd1000, 32'd3, 32'd333, 34);

    run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_op("DIV by0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("REM by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);

    // Asynchronous reset at cycle 5 of a MUL.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd9;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("pre-rst busy/alu", {busy_o, alu_req_o}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("rst ctl", {busy_o, valid_o, alu_req_o, alu_sub_o}, 0);
    chk("rst result", result_o, 0);
    chk("rst opa", opa, 0);
    @(negedge clk);
    rst = 1'b0;

    // Stray start at cycle 3 must be ignored.
    run_op("MULHU busy start", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 3);

    run_op("MUL zero", 3'b000, 32'd0, 32'd123, 32'd0, EL);
    run_op("DIVU small", 3'b101, 32'd3, 32'd9, 32'd0, EL);
    run_op("REMU small", 3'b111, 32'd3, 32'd9, 32'd3, EL);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
